// File: rtl/instr_decode_stage.sv
// LEGv8 decode stage: classifies format, extracts fields, extends immediate.
// Latency: 1 cycle from accepted input to out_valid.
// Backpressure: 2-entry (output + skid) buffer; in_ready = ~skid_valid, registered.
module instr_decode_stage #(
  parameter int IMM_W  = 64,
  parameter int ADDR_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [ADDR_W-1:0] in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [10:0]       out_opcode,
  output logic [2:0]        out_fmt,
  output logic [4:0]        out_rm,
  output logic [4:0]        out_rn,
  output logic [4:0]        out_rd,
  output logic [5:0]        out_shamt,
  output logic [IMM_W-1:0]  out_imm,
  output logic              out_illegal,
  output logic [CNT_W-1:0]  decoded_cnt
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_D   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_CB  = 3'd4;
  localparam logic [2:0] FMT_IW  = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  // One decoded record, held in both the output register and the skid entry.
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [10:0]       opcode;
    logic [2:0]        fmt;
    logic [4:0]        rm;
    logic [4:0]        rn;
    logic [4:0]        rd;
    logic [5:0]        shamt;
    logic [IMM_W-1:0]  imm;
    logic              illegal;
  } rec_t;

  rec_t             dec;
  rec_t             out_q, out_d;
  rec_t             skid_q, skid_d;
  logic             out_valid_q, out_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic accept;
  logic load;
  logic xfer;

  assign in_ready = ~skid_valid_q;
  assign accept   = in_valid & in_ready;
  assign load     = ~out_valid_q | out_ready;
  assign xfer     = out_valid_q & out_ready;

  // Decode the incoming instruction; formats are tested widest-opcode-last so the first match wins.
  always_comb begin
    dec         = '0;
    dec.pc      = in_pc;
    dec.opcode  = in_instr[31:21];
    dec.rm      = in_instr[20:16];
    dec.rn      = in_instr[9:5];
    dec.rd      = in_instr[4:0];
    dec.shamt   = in_instr[15:10];
    dec.fmt     = FMT_ILL;
    dec.illegal = 1'b0;
    if (in_instr[31:26] inside {6'b000101, 6'b100101}) begin
      dec.fmt = FMT_B;
      dec.imm = {{(IMM_W-26){in_instr[25]}}, in_instr[25:0]};
    end else if (in_instr[31:24] inside {8'b10110100, 8'b10110101, 8'b01010100}) begin
      dec.fmt = FMT_CB;
      dec.imm = {{(IMM_W-19){in_instr[23]}}, in_instr[23:5]};
    end else if (in_instr[31:23] inside {9'b110100101, 9'b111100101}) begin
      // Shift amount (hw) stays in opcode bits [1:0]; the immediate is the raw 16 bits.
      dec.fmt = FMT_IW;
      dec.imm = {{(IMM_W-16){1'b0}}, in_instr[20:5]};
    end else if (in_instr[31:22] inside {10'b1001000100, 10'b1101000100,
                                         10'b1001001000, 10'b1011001000}) begin
      dec.fmt = FMT_I;
      dec.imm = {{(IMM_W-12){1'b0}}, in_instr[21:10]};
    end else if (in_instr[31:21] inside {11'b11111000010, 11'b11111000000}) begin
      dec.fmt = FMT_D;
      dec.imm = {{(IMM_W-9){in_instr[20]}}, in_instr[20:12]};
    end else if (in_instr[31:21] inside {11'b10001011000, 11'b11001011000, 11'b10001010000,
                                         11'b10101010000, 11'b11010011011, 11'b11010011010,
                                         11'b11010110000}) begin
      dec.fmt = FMT_R;
    end else begin
      dec.fmt     = FMT_ILL;
      dec.illegal = 1'b1;
    end
  end

  // Next-state for output register, skid entry and saturating delivery counter.
  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    cnt_d        = cnt_q;

    if (xfer && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end

    if (flush) begin
      // Everything held or arriving this cycle is dropped; a completing transfer still counted above.
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (load) begin
      if (skid_valid_q) begin
        // in_ready is low whenever skid is occupied, so no new input competes here.
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_d       = dec;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      // Output stalled: park the new record behind it to keep order.
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
  end

  // State registers with asynchronous reset discarding any held records.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      cnt_q        <= cnt_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_pc      = out_q.pc;
  assign out_opcode  = out_q.opcode;
  assign out_fmt     = out_q.fmt;
  assign out_rm      = out_q.rm;
  assign out_rn      = out_q.rn;
  assign out_rd      = out_q.rd;
  assign out_shamt   = out_q.shamt;
  assign out_imm     = out_q.imm;
  assign out_illegal = out_q.illegal;
  assign decoded_cnt = cnt_q;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed bench for instr_decode_stage: decode vectors, stall/skid, flush, saturation, async reset.
// Inputs driven 1 time unit after the rising edge; registered outputs checked at the same point.
// Counter width reduced to 4 bits so saturation is reachable in a few cycles.
module tb_instr_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [10:0] out_opcode;
  logic [2:0]  out_fmt;
  logic [4:0]  out_rm;
  logic [4:0]  out_rn;
  logic [4:0]  out_rd;
  logic [5:0]  out_shamt;
  logic [63:0] out_imm;
  logic        out_illegal;
  logic [3:0]  decoded_cnt;

  int total = 0;
  int bad   = 0;

  instr_decode_stage #(.IMM_W(64), .ADDR_W(64), .CNT_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_opcode  (out_opcode),
    .out_fmt     (out_fmt),
    .out_rm      (out_rm),
    .out_rn      (out_rn),
    .out_rd      (out_rd),
    .out_shamt   (out_shamt),
    .out_imm     (out_imm),
    .out_illegal (out_illegal),
    .decoded_cnt (decoded_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rec(input string tag, input logic [63:0] pc, input logic [2:0] fmt,
                         input logic [10:0] opc, input logic [4:0] rm, input logic [4:0] rn,
                         input logic [4:0] rd, input logic [5:0] sh, input logic [63:0] imm,
                         input logic ill);
    chk({tag, ".valid"},   64'(out_valid),   64'd1);
    chk({tag, ".pc"},      out_pc,           pc);
    chk({tag, ".fmt"},     64'(out_fmt),     64'(fmt));
    chk({tag, ".opcode"},  64'(out_opcode),  64'(opc));
    chk({tag, ".rm"},      64'(out_rm),      64'(rm));
    chk({tag, ".rn"},      64'(out_rn),      64'(rn));
    chk({tag, ".rd"},      64'(out_rd),      64'(rd));
    chk({tag, ".shamt"},   64'(out_shamt),   64'(sh));
    chk({tag, ".imm"},     out_imm,          imm);
    chk({tag, ".illegal"}, 64'(out_illegal), 64'(ill));
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
    step(); step();
    // Reset values
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.in_ready",  64'(in_ready),  64'd1);
    chk("rst.out_pc",    out_pc,         64'd0);
    chk("rst.out_imm",   out_imm,        64'd0);
    chk("rst.opcode",    64'(out_opcode), 64'd0);
    chk("rst.cnt",       64'(decoded_cnt), 64'd0);
    rst = 1'b0;

    // Streaming decode, out_ready high
    out_ready = 1'b1;
    in_valid = 1'b1; in_instr = 32'hF84F02C9; in_pc = 64'h1000;    // LDUR
    step();
    chk_rec("ldur", 64'h1000, 3'd2, 11'h7C2, 5'd15, 5'd22, 5'd9, 6'd0, 64'd240, 1'b0);
    chk("ldur.cnt", 64'(decoded_cnt), 64'd0);
    in_instr = 32'h8B0902AA; in_pc = 64'h1004;                       // ADD
    step();
    chk_rec("add", 64'h1004, 3'd0, 11'h458, 5'd9, 5'd21, 5'd10, 6'd0, 64'd0, 1'b0);
    chk("add.cnt", 64'(decoded_cnt), 64'd1);
    in_instr = 32'hF80402EA; in_pc = 64'h1008;                       // STUR
    step();
    chk_rec("stur", 64'h1008, 3'd2, 11'h7C0, 5'd4, 5'd23, 5'd10, 6'd0, 64'd64, 1'b0);
    in_instr = 32'hB4FFFF83; in_pc = 64'h100C;                       // CBZ X3,#-4
    step();
    chk_rec("cbz", 64'h100C, 3'd4, 11'h5A7, 5'd31, 5'd28, 5'd3, 6'd63,
            64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    in_instr = 32'h00000000; in_pc = 64'h1010;                       // illegal
    step();
    chk_rec("ill", 64'h1010, 3'd7, 11'h000, 5'd0, 5'd0, 5'd0, 6'd0, 64'd0, 1'b1);
    in_instr = 32'h17FFFFFF; in_pc = 64'h1014;                       // B #-1
    step();
    chk_rec("b", 64'h1014, 3'd3, 11'h0BF, 5'd31, 5'd31, 5'd31, 6'd63,
            64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    in_instr = 32'hD2B579A1; in_pc = 64'h1018;                       // MOVZ X1,#0xABCD,LSL 16
    step();
    chk_rec("movz", 64'h1018, 3'd5, 11'h695, 5'd21, 5'd13, 5'd1, 6'd30, 64'hABCD, 1'b0);
    in_instr = 32'h913FFC62; in_pc = 64'h101C;                       // ADDI X2,X3,#4095
    step();
    chk_rec("addi", 64'h101C, 3'd1, 11'h489, 5'd31, 5'd3, 5'd2, 6'd63, 64'hFFF, 1'b0);
    chk("addi.cnt", 64'(decoded_cnt), 64'd7);
    in_valid = 1'b0;
    step();
    chk("drain.valid", 64'(out_valid), 64'd0);
    chk("drain.cnt", 64'(decoded_cnt), 64'd8);

    // Back-to-back 3 with out_ready low 2 cycles
    in_valid = 1'b1; in_instr = 32'h8B0902AA; in_pc = 64'h2000;
    step();
    chk("stl.a.pc", out_pc, 64'h2000);
    chk("stl.a.rdy", 64'(in_ready), 64'd1);
    out_ready = 1'b0; in_instr = 32'hF80402EA; in_pc = 64'h2004;
    step();
    chk("stl.b.pc", out_pc, 64'h2000);
    chk("stl.b.rdy", 64'(in_ready), 64'd0);
    chk("stl.b.valid", 64'(out_valid), 64'd1);
    in_instr = 32'hF84F02C9; in_pc = 64'h2008;
    step();
    chk("stl.c.pc", out_pc, 64'h2000);
    chk("stl.c.opc", 64'(out_opcode), 64'h458);
    chk("stl.c.rdy", 64'(in_ready), 64'd0);
    chk("stl.c.cnt", 64'(decoded_cnt), 64'd8);
    out_ready = 1'b1;
    step();
    chk("stl.d.pc", out_pc, 64'h2004);
    chk("stl.d.opc", 64'(out_opcode), 64'h7C0);
    chk("stl.d.rdy", 64'(in_ready), 64'd1);
    chk("stl.d.cnt", 64'(decoded_cnt), 64'd9);
    step();
    chk("stl.e.pc", out_pc, 64'h2008);
    chk("stl.e.opc", 64'(out_opcode), 64'h7C2);
    in_valid = 1'b0;
    step();
    chk("stl.f.valid", 64'(out_valid), 64'd0);
    chk("stl.f.cnt", 64'(decoded_cnt), 64'd11);

    // Flush with both entries full
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h8B0902AA; in_pc = 64'h3000;
    step();
    in_pc = 64'h3004;
    step();
    chk("fl.full.rdy", 64'(in_ready), 64'd0);
    chk("fl.full.valid", 64'(out_valid), 64'd1);
    flush = 1'b1;
    step();
    chk("fl.valid", 64'(out_valid), 64'd0);
    chk("fl.rdy", 64'(in_ready), 64'd1);
    chk("fl.cnt", 64'(decoded_cnt), 64'd11);
    // Flush with a completing transfer and a same-cycle input
    flush = 1'b0; out_ready = 1'b1; in_pc = 64'h4000;
    step();
    chk("fl2.pc", out_pc, 64'h4000);
    flush = 1'b1; in_pc = 64'h4004;
    step();
    chk("fl2.valid", 64'(out_valid), 64'd0);
    chk("fl2.cnt", 64'(decoded_cnt), 64'd12);
    flush = 1'b0; in_valid = 1'b0;
    step();
    chk("fl2.drop", 64'(out_valid), 64'd0);

    // Counter saturation
    in_valid = 1'b1; in_pc = 64'h5000;
    for (int i = 0; i < 10; i++) begin
      step();
    end
    chk("sat.cnt", 64'(decoded_cnt), 64'd15);

    // Async reset mid-stream with both entries full
    out_ready = 1'b0; in_pc = 64'h6000;
    step();
    in_pc = 64'h6004;
    step();
    chk("mid.rdy", 64'(in_ready), 64'd0);
    rst = 1'b1;
    #2;
    chk("arst.valid", 64'(out_valid), 64'd0);
    chk("arst.rdy",   64'(in_ready),  64'd1);
    chk("arst.pc",    out_pc,         64'd0);
    chk("arst.cnt",   64'(decoded_cnt), 64'd0);
    in_valid = 1'b0;
    step();
    rst = 1'b0;
    step();
    chk("post.valid", 64'(out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
